// File: rtl/merge_pkg.sv
// merge_pkg
//   Shared constants and types for the 14-input merge block.
//   NUM_IN     number of input channels
//   SRC_W      width of a channel index
//   src_idx_t  channel index type
//   arb_state_t  arbitration FSM state
package merge_pkg;

  localparam int NUM_IN = 14;
  localparam int SRC_W  = 4;

  typedef logic [SRC_W-1:0] src_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    STALL
  } arb_state_t;

endpackage

// File: rtl/merge_14in_rr_arb14.sv
// rr_arb14
//   Combinational round-robin arbiter over 14 requesters. The search
//   begins one past last_grant and wraps from 13 back to 0.
//   Ports:
//     req[13:0]   request per channel
//     last_grant  index of the previously accepted channel
//     enable      when low no grant is issued
//     gnt[13:0]   one-hot grant (all zero when nothing wins)
//     gnt_idx     binary index of the granted channel (0 when none)
module rr_arb14
  import merge_pkg::*;
(
  input  logic [NUM_IN-1:0] req,
  input  src_idx_t          last_grant,
  input  logic              enable,
  output logic [NUM_IN-1:0] gnt,
  output src_idx_t          gnt_idx
);

  localparam int SUM_W = SRC_W + 1;

  logic             found;
  logic [SUM_W-1:0] sum;
  src_idx_t         idx;

  // last_grant <= 13 and offset <= 14, so a single subtraction of 14
  // brings the candidate back into range.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      sum = {1'b0, last_grant} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_IN)) begin
        sum = sum - SUM_W'(NUM_IN);
      end
      idx = sum[SRC_W-1:0];
      if (enable && !found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/merge_14in.sv
// merge_14in
//   Merges 14 valid/ready channels into one stream through a small FIFO.
//   A round-robin arbiter picks at most one channel per cycle; accepted
//   words enter the FIFO one cycle later and leave in acceptance order.
//   Optional feature: define MERGE_SRC_TAG_EN to store the source channel
//   index beside each word and present it on out_src.
//   Ports:
//     clk        clock
//     rst        synchronous active-high reset
//     in_valid   per-channel request [13:0]
//     in_data    per-channel payload, channel i at [i*WIDTH +: WIDTH]
//     in_ready   per-channel accept (at most one bit high)
//     out_valid  FIFO head valid
//     out_data   FIFO head payload (holds its last value when empty)
//     out_ready  downstream accept
//     out_src    FIFO head source channel (MERGE_SRC_TAG_EN only)
//
//   Arbitration FSM
//   state | meaning
//   IDLE  | no channel requesting
//   GRANT | a requesting channel is accepted this cycle
//   STALL | channels requesting but FIFO full with no pop
module merge_14in
  import merge_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2   // 2, 4 or 8
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready
`ifdef MERGE_SRC_TAG_EN
  ,
  output logic [SRC_W-1:0]        out_src
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
`ifdef MERGE_SRC_TAG_EN
  src_idx_t          mem_src [DEPTH];
`endif
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_inc;
  logic [CNT_W-1:0]  count;
  src_idx_t          last_grant;
  src_idx_t          gnt_idx;
  logic [NUM_IN-1:0] gnt;
  logic [WIDTH-1:0]  push_word;
  logic              full;
  logic              pop;
  logic              push;
  logic              arb_en;
  arb_state_t        state;

  assign full       = (count == CNT_W'(DEPTH));
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign arb_en     = !rst && (!full || pop);
  assign push       = |gnt;
  assign in_ready   = gnt;
  assign rd_ptr_inc = rd_ptr + 1'b1;

  rr_arb14 u_arb (
    .req        (in_valid),
    .last_grant (last_grant),
    .enable     (arb_en),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  always_comb begin
    push_word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt[i]) begin
        push_word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_word;
`ifdef MERGE_SRC_TAG_EN
      mem_src[wr_ptr] <= gnt_idx;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= src_idx_t'(NUM_IN - 1);
      out_data   <= '0;
`ifdef MERGE_SRC_TAG_EN
      out_src    <= '0;
`endif
      state      <= IDLE;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        last_grant <= gnt_idx;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // The head is kept in a register so it stays put when the FIFO
      // drains; it only moves when a new word becomes the head.
      if (pop) begin
        if (count > CNT_W'(1)) begin
          out_data <= mem[rd_ptr_inc];
`ifdef MERGE_SRC_TAG_EN
          out_src  <= mem_src[rd_ptr_inc];
`endif
        end else if (push) begin
          out_data <= push_word;
`ifdef MERGE_SRC_TAG_EN
          out_src  <= gnt_idx;
`endif
        end
      end else if (!out_valid && push) begin
        out_data <= push_word;
`ifdef MERGE_SRC_TAG_EN
        out_src  <= gnt_idx;
`endif
      end

      case (state)
        IDLE: begin
          if (in_valid != '0) begin
            state <= (full && !pop) ? STALL : GRANT;
          end
        end
        GRANT, STALL: begin
          if (in_valid == '0) begin
            state <= IDLE;
          end else if (full && !pop) begin
            state <= STALL;
          end else begin
            state <= GRANT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_merge_14in.sv
module tb_merge_14in;
  import merge_pkg::*;

  localparam int W = 4;
  localparam int D = 2;

  logic              clk;
  logic              rst;
  logic [13:0]       in_valid;
  logic [14*W-1:0]   in_data;
  logic [13:0]       in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic              out_ready;
`ifdef MERGE_SRC_TAG_EN
  logic [3:0]        out_src;
`endif

  merge_14in #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef MERGE_SRC_TAG_EN
    ,
    .out_src   (out_src)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // channel i carries i; optional override puts 4'hA on channel 0
  function automatic logic [14*W-1:0] mk_data(input logic apat);
    logic [14*W-1:0] d;
    for (int i = 0; i < 14; i++) d[i*W +: W] = W'(i);
    if (apat) d[W-1:0] = 4'hA;
    return d;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; out_ready = 1'b0; in_data = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic [13:0] v;
    logic        apat;
    logic        ory;
    logic [13:0] er;
    logic        eov;
    logic [3:0]  eod;
    int          ecnt;
    arb_state_t  est;
  } vec_t;

  vec_t tbl [16];

  // behavioural reference: a queue of accepted words and the last winner
  int q_d [$];
  int q_s [$];
  int lg;

  task automatic model_cycle();
    int win;
    bit full_m, pop_m;
    logic [13:0] exp_r;
    @(negedge clk);
    full_m = (q_d.size() == D);
    pop_m  = (q_d.size() > 0) && out_ready;
    win = -1;
    if (!rst && (!full_m || pop_m)) begin
      for (int k = 1; k <= 14; k++) begin
        int ch;
        ch = (lg + k) % 14;
        if (win < 0 && in_valid[ch]) win = ch;
      end
    end
    exp_r = (win >= 0) ? (14'd1 << win) : 14'd0;
    chk("rnd_ready", in_ready, exp_r);
    chk("rnd_ovalid", out_valid, q_d.size() > 0);
    if (q_d.size() > 0) begin
      chk("rnd_odata", out_data, q_d[0]);
`ifdef MERGE_SRC_TAG_EN
      chk("rnd_osrc", out_src, q_s[0]);
`endif
    end
    @(posedge clk);
    if (rst) begin
      q_d.delete(); q_s.delete(); lg = 13;
    end else begin
      if (pop_m) begin void'(q_d.pop_front()); void'(q_s.pop_front()); end
      if (win >= 0) begin
        q_d.push_back(int'(in_data[win*W +: W]));
        q_s.push_back(win);
        lg = win;
      end
    end
    #1;
  endtask

  initial begin
    logic [63:0] rnd;

    tbl[0]  = '{1'b1, 14'h0001, 1'b1, 1'b1, 14'h0000, 1'b0, 4'h0, 0, IDLE};
    tbl[1]  = '{1'b0, 14'h0001, 1'b1, 1'b1, 14'h0001, 1'b0, 4'h0, 0, IDLE};
    tbl[2]  = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h0000, 1'b1, 4'hA, 1, GRANT};
    tbl[3]  = '{1'b0, 14'h0000, 1'b1, 1'b1, 14'h0000, 1'b0, 4'hA, 0, IDLE};
    tbl[4]  = '{1'b0, 14'h0088, 1'b0, 1'b0, 14'h0008, 1'b0, 4'hA, 0, IDLE};
    tbl[5]  = '{1'b0, 14'h0088, 1'b0, 1'b0, 14'h0080, 1'b1, 4'h3, 1, GRANT};
    tbl[6]  = '{1'b0, 14'h0088, 1'b0, 1'b0, 14'h0000, 1'b1, 4'h3, 2, GRANT};
    tbl[7]  = '{1'b0, 14'h0088, 1'b0, 1'b0, 14'h0000, 1'b1, 4'h3, 2, STALL};
    tbl[8]  = '{1'b0, 14'h0088, 1'b0, 1'b1, 14'h0008, 1'b1, 4'h3, 2, STALL};
    tbl[9]  = '{1'b0, 14'h0000, 1'b0, 1'b1, 14'h0000, 1'b1, 4'h7, 2, GRANT};
    tbl[10] = '{1'b0, 14'h0000, 1'b0, 1'b1, 14'h0000, 1'b1, 4'h3, 1, IDLE};
    tbl[11] = '{1'b0, 14'h0000, 1'b0, 1'b1, 14'h0000, 1'b0, 4'h3, 0, IDLE};
    tbl[12] = '{1'b0, 14'h0030, 1'b0, 1'b0, 14'h0010, 1'b0, 4'h3, 0, IDLE};
    tbl[13] = '{1'b0, 14'h0030, 1'b0, 1'b0, 14'h0020, 1'b1, 4'h4, 1, GRANT};
    tbl[14] = '{1'b1, 14'h0030, 1'b0, 1'b0, 14'h0000, 1'b1, 4'h4, 2, GRANT};
    tbl[15] = '{1'b0, 14'h0021, 1'b0, 1'b0, 14'h0001, 1'b0, 4'h0, 0, IDLE};

    do_reset();

    for (int r = 0; r < 16; r++) begin
      rst       = tbl[r].rst;
      in_valid  = tbl[r].v;
      in_data   = mk_data(tbl[r].apat);
      out_ready = tbl[r].ory;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r), in_ready, tbl[r].er);
      chk($sformatf("tbl%0d_ovalid", r), out_valid, tbl[r].eov);
      chk($sformatf("tbl%0d_odata", r), out_data, tbl[r].eod);
      chk($sformatf("tbl%0d_count", r), dut.count, tbl[r].ecnt);
      chk($sformatf("tbl%0d_state", r), dut.state, tbl[r].est);
      @(posedge clk); #1;
    end

    // all channels valid: grants rotate 0..13,0,1 and data trails by one cycle
    do_reset();
    in_valid = 14'h3FFF; in_data = mk_data(1'b0); out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk($sformatf("rot%0d_ready", c), in_ready, 14'd1 << (c % 14));
      chk($sformatf("rot%0d_ovalid", c), out_valid, c > 0);
      if (c > 0) chk($sformatf("rot%0d_odata", c), out_data, (c - 1) % 14);
      @(posedge clk); #1;
    end

    // channel 13 alone right after reset wins through the wrap
    do_reset();
    in_valid = 14'h2000; in_data = mk_data(1'b0); out_ready = 1'b1;
    @(negedge clk);
    chk("wrap_ready", in_ready, 14'h2000);
    @(posedge clk); #1;
    in_valid = '0;
    @(negedge clk);
    chk("wrap_ovalid", out_valid, 1'b1);
    chk("wrap_odata", out_data, 4'hD);
`ifdef MERGE_SRC_TAG_EN
    chk("wrap_osrc", out_src, 4'd13);
`endif
    @(posedge clk); #1;

    // randomized traffic against the queue model
    do_reset();
    q_d.delete(); q_s.delete(); lg = 13;
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 3))
        0:       in_valid = '0;
        1:       in_valid = 14'd1 << $urandom_range(0, 13);
        default: in_valid = 14'($urandom);
      endcase
      rnd = {$urandom, $urandom};
      in_data   = rnd[14*W-1:0];
      out_ready = ($urandom_range(0, 2) != 0);
      model_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
